// File: rtl/ball_motion_ctrl.sv
// Pong frame sequencer: latches collisions across the active frame,
// resolves them once per VBlank tick, and runs serve/point/over flow.
module ball_motion_ctrl #(
  parameter int p_SERVE_FRAMES = 60,
  parameter int p_POINT_FRAMES = 30,
  parameter int p_WIN_SCORE    = 9,
  parameter int p_SCORE_W      = 4
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_VBlank,
  input  logic                 i_Start,
  input  logic                 i_Hit_Top,
  input  logic                 i_Hit_Bottom,
  input  logic                 i_Hit_Paddle_L,
  input  logic                 i_Hit_Paddle_R,
  input  logic                 i_Miss_L,
  input  logic                 i_Miss_R,
  output logic                 o_VDir,
  output logic                 o_HDir,
  output logic                 o_Ball_En,
  output logic                 o_Ball_Reset,
  output logic                 o_Frame,
  output logic [p_SCORE_W-1:0] o_Score_L,
  output logic [p_SCORE_W-1:0] o_Score_R,
  output logic                 o_Game_Over
);

  localparam int MAX_F =
    (p_SERVE_FRAMES > p_POINT_FRAMES) ?
    p_SERVE_FRAMES : p_POINT_FRAMES;
  localparam int CNT_W = $clog2(MAX_F) + 1;

  localparam logic [CNT_W-1:0] SERVE_LAST =
    CNT_W'(p_SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LAST =
    CNT_W'(p_POINT_FRAMES - 1);
  localparam logic [p_SCORE_W-1:0] WIN =
    p_SCORE_W'(p_WIN_SCORE);

  localparam int E_TOP    = 0;
  localparam int E_BOT    = 1;
  localparam int E_PAD_L  = 2;
  localparam int E_PAD_R  = 3;
  localparam int E_MISS_L = 4;
  localparam int E_MISS_R = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_POINT,
    S_OVER
  } state_t;

  state_t               state, state_nxt;
  logic                 vb_q, frame_q;
  logic [5:0]           evt_q, evt_nxt, evt_in, evt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic [p_SCORE_W-1:0] score_l_q, score_l_nxt;
  logic [p_SCORE_W-1:0] score_r_q, score_r_nxt;
  logic                 vdir_q, vdir_nxt;
  logic                 hdir_q, hdir_nxt;
  logic                 ball_reset_q;
  logic                 miss_any, score_win;

  function automatic logic [p_SCORE_W-1:0] sat_inc(
    input logic [p_SCORE_W-1:0] s
  );
    return (s == WIN) ? s : s + 1'b1;
  endfunction

  assign evt_in = {i_Miss_R, i_Miss_L,
                   i_Hit_Paddle_R, i_Hit_Paddle_L,
                   i_Hit_Bottom, i_Hit_Top};
  // live input counts too, so an event on the tick cycle is not lost
  assign evt       = evt_q | evt_in;
  assign miss_any  = evt[E_MISS_L] | evt[E_MISS_R];
  assign score_win = (score_l_q == WIN) ||
                     (score_r_q == WIN);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt_q;
    evt_nxt     = '0;
    score_l_nxt = score_l_q;
    score_r_nxt = score_r_q;
    vdir_nxt    = vdir_q;
    hdir_nxt    = hdir_q;
    unique case (state)
      S_IDLE: begin
        if (i_Start) state_nxt = S_SERVE;
      end
      S_SERVE: begin
        if (frame_q) begin
          if (cnt_q == SERVE_LAST) state_nxt = S_PLAY;
          else cnt_nxt = cnt_q + 1'b1;
        end
      end
      S_PLAY: begin
        if (!frame_q) begin
          evt_nxt = evt;
        end else begin
          if (evt[E_TOP] && !evt[E_BOT]) vdir_nxt = 1'b1;
          if (evt[E_BOT] && !evt[E_TOP]) vdir_nxt = 1'b0;
          if (miss_any) begin
            state_nxt = S_POINT;
            // serve goes toward the player who missed
            if (evt[E_MISS_L] && !evt[E_MISS_R]) begin
              score_r_nxt = sat_inc(score_r_q);
              hdir_nxt    = 1'b0;
            end
            if (evt[E_MISS_R] && !evt[E_MISS_L]) begin
              score_l_nxt = sat_inc(score_l_q);
              hdir_nxt    = 1'b1;
            end
          end else if (evt[E_PAD_L] && evt[E_PAD_R]) begin
            hdir_nxt = ~hdir_q;
          end else if (evt[E_PAD_L]) begin
            hdir_nxt = 1'b1;
          end else if (evt[E_PAD_R]) begin
            hdir_nxt = 1'b0;
          end
        end
      end
      S_POINT: begin
        if (frame_q) begin
          if (cnt_q == POINT_LAST)
            state_nxt = score_win ? S_OVER : S_SERVE;
          else
            cnt_nxt = cnt_q + 1'b1;
        end
      end
      S_OVER: begin
        if (i_Start) begin
          state_nxt   = S_SERVE;
          score_l_nxt = '0;
          score_r_nxt = '0;
          vdir_nxt    = 1'b1;
          hdir_nxt    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state        <= S_IDLE;
      vb_q         <= 1'b0;
      frame_q      <= 1'b0;
      evt_q        <= '0;
      cnt_q        <= '0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      vdir_q       <= 1'b1;
      hdir_q       <= 1'b1;
      ball_reset_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      vb_q         <= i_VBlank;
      frame_q      <= i_VBlank & ~vb_q;
      evt_q        <= evt_nxt;
      cnt_q        <= cnt_nxt;
      score_l_q    <= score_l_nxt;
      score_r_q    <= score_r_nxt;
      vdir_q       <= vdir_nxt;
      hdir_q       <= hdir_nxt;
      ball_reset_q <= (state_nxt == S_SERVE) &&
                      (state != S_SERVE);
    end
  end

  assign o_VDir       = vdir_q;
  assign o_HDir       = hdir_q;
  assign o_Ball_En    = (state == S_PLAY);
  assign o_Ball_Reset = ball_reset_q;
  assign o_Frame      = frame_q;
  assign o_Score_L    = score_l_q;
  assign o_Score_R    = score_r_q;
  assign o_Game_Over  = (state == S_OVER);

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: frame-level game model compared
// every cycle, plus directed literal checks of the game flow.
module tb_ball_motion_ctrl;

  localparam int SERVE_N = 60;
  localparam int POINT_N = 30;
  localparam int WIN     = 9;

  localparam logic [5:0] TOP   = 6'b000001;
  localparam logic [5:0] BOT   = 6'b000010;
  localparam logic [5:0] PADL  = 6'b000100;
  localparam logic [5:0] PADR  = 6'b001000;
  localparam logic [5:0] MISSL = 6'b010000;
  localparam logic [5:0] MISSR = 6'b100000;
  localparam logic [5:0] NONE  = 6'b000000;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       vblank = 1'b0;
  logic       start  = 1'b0;
  logic [5:0] ev     = '0;
  logic       vdir, hdir, ball_en, ball_reset;
  logic       frame_p, game_over;
  logic [3:0] score_l, score_r;

  int tests      = 0;
  int fails      = 0;
  int rst_pulses = 0;

  always #5 clk = ~clk;

  ball_motion_ctrl dut (
    .i_Clk          (clk),
    .i_Rst_n        (rst_n),
    .i_VBlank       (vblank),
    .i_Start        (start),
    .i_Hit_Top      (ev[0]),
    .i_Hit_Bottom   (ev[1]),
    .i_Hit_Paddle_L (ev[2]),
    .i_Hit_Paddle_R (ev[3]),
    .i_Miss_L       (ev[4]),
    .i_Miss_R       (ev[5]),
    .o_VDir         (vdir),
    .o_HDir         (hdir),
    .o_Ball_En      (ball_en),
    .o_Ball_Reset   (ball_reset),
    .o_Frame        (frame_p),
    .o_Score_L      (score_l),
    .o_Score_R      (score_r),
    .o_Game_Over    (game_over)
  );

  // game model: modes with a frames-remaining countdown
  localparam int M_IDLE  = 0;
  localparam int M_SERVE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_POINT = 3;
  localparam int M_OVER  = 4;

  int         m_mode, m_left, m_sl, m_sr;
  bit         m_down, m_right, m_tick, m_vb;
  bit         m_recentre, m_now;
  logic [5:0] m_seen, m_ev;
  bit         t, b, pl, pr, ml, mr;

  task automatic enter_serve();
    m_mode     = M_SERVE;
    m_left     = SERVE_N;
    m_recentre = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_left = 0;
      m_sl = 0; m_sr = 0;
      m_down = 1'b1; m_right = 1'b1;
      m_tick = 1'b0; m_vb = 1'b0;
      m_recentre = 1'b0; m_seen = '0;
    end else begin
      m_now      = m_tick;
      m_tick     = vblank && !m_vb;
      m_vb       = vblank;
      m_recentre = 1'b0;
      m_ev       = m_seen | ev;
      m_seen     = (m_mode == M_PLAY && !m_now) ? m_ev : '0;
      {mr, ml, pr, pl, b, t} = m_ev;
      case (m_mode)
        M_IDLE: if (start) enter_serve();
        M_SERVE: if (m_now) begin
          m_left--;
          if (m_left == 0) m_mode = M_PLAY;
        end
        M_PLAY: if (m_now) begin
          if (t != b) m_down = t;
          if (ml || mr) begin
            if (ml && !mr) begin
              m_sr = (m_sr < WIN) ? m_sr + 1 : m_sr;
              m_right = 1'b0;
            end
            if (mr && !ml) begin
              m_sl = (m_sl < WIN) ? m_sl + 1 : m_sl;
              m_right = 1'b1;
            end
            m_mode = M_POINT;
            m_left = POINT_N;
          end else if (pl && pr) m_right = !m_right;
          else if (pl) m_right = 1'b1;
          else if (pr) m_right = 1'b0;
        end
        M_POINT: if (m_now) begin
          m_left--;
          if (m_left == 0) begin
            if (m_sl == WIN || m_sr == WIN) m_mode = M_OVER;
            else enter_serve();
          end
        end
        M_OVER: if (start) begin
          m_sl = 0; m_sr = 0;
          m_down = 1'b1; m_right = 1'b1;
          enter_serve();
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  logic [13:0] got_v, exp_v;

  always @(negedge clk) begin
    got_v = {vdir, hdir, ball_en, ball_reset, frame_p,
             game_over, score_l, score_r};
    exp_v = {m_down, m_right, m_mode == M_PLAY, m_recentre,
             m_tick, m_mode == M_OVER, 4'(m_sl), 4'(m_sr)};
    tests++;
    if (got_v !== exp_v) begin
      fails++;
      $display("FAIL model_cycle t=%0t got=%b exp=%b",
               $time, got_v, exp_v);
    end
    if (ball_reset === 1'b1) rst_pulses++;
  end

  task automatic check(input string name,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // one frame: events a/b mid-frame, f during the tick cycle
  task automatic frame(input logic [5:0] a,
                       input logic [5:0] bb,
                       input logic [5:0] f);
    for (int i = 0; i < 6; i++) begin
      ev = (i == 1) ? a : ((i == 3) ? bb : NONE);
      @(negedge clk);
    end
    ev = NONE;
    vblank = 1'b1;
    @(negedge clk);
    ev = f;
    @(negedge clk);
    ev = NONE;
    vblank = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(NONE, NONE, NONE);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_vdir", vdir, 1);
    check("rst_hdir", hdir, 1);
    check("rst_ball_en", ball_en, 0);
    check("rst_game_over", game_over, 0);
    check("rst_score_l", score_l, 0);

    // serve timing
    @(negedge clk);
    pulse_start();
    check("serve_ball_reset", ball_reset, 1);
    for (int k = 1; k <= SERVE_N; k++) begin
      frame(NONE, NONE, NONE);
      if (k == SERVE_N - 1) check("serve_59_en", ball_en, 0);
    end
    check("serve_60_en", ball_en, 1);
    check("serve_pulses", 8'(rst_pulses), 1);

    // wall and paddle resolution, latch clearing
    frame(BOT, PADR, NONE);
    check("bot_padr_vdir", vdir, 0);
    check("bot_padr_hdir", hdir, 0);
    frame(NONE, NONE, TOP);
    check("tick_top_vdir", vdir, 1);
    frame(BOT, NONE, NONE);
    check("no_carry_vdir", vdir, 0);
    frame(PADL, NONE, NONE);
    check("padl_hdir", hdir, 1);
    frame(PADL, PADR, NONE);
    check("both_pad_toggle", hdir, 0);
    frame(PADR, NONE, PADL);
    check("both_pad_toggle2", hdir, 1);

    // miss beats paddle
    frame(MISSL, PADL, NONE);
    check("missl_score_r", score_r, 1);
    check("missl_score_l", score_l, 0);
    check("missl_hdir", hdir, 0);
    check("missl_en", ball_en, 0);
    frames(POINT_N - 1);
    check("point_29_reset", ball_reset, 0);
    frame(NONE, NONE, NONE);
    check("point_30_reset", ball_reset, 1);
    frames(SERVE_N);
    check("replay_en", ball_en, 1);

    // double miss, double wall
    frame(MISSL | MISSR, NONE, NONE);
    check("dbl_miss_r", score_r, 1);
    check("dbl_miss_l", score_l, 0);
    check("dbl_miss_hdir", hdir, 0);
    check("dbl_miss_en", ball_en, 0);
    frames(POINT_N + SERVE_N);
    frame(TOP, NONE, NONE);
    frame(TOP | BOT, NONE, NONE);
    check("dbl_wall_up", vdir, 1);
    frame(BOT, NONE, NONE);
    frame(TOP, NONE, BOT);
    check("dbl_wall_down", vdir, 0);

    // run left score to the win value
    for (int p = 1; p <= WIN; p++) begin
      frame(MISSR, NONE, NONE);
      check("win_run_score_l", score_l, 8'(p));
      frames(POINT_N);
      if (p < WIN) frames(SERVE_N);
    end
    check("over_flag", game_over, 1);
    check("over_en", ball_en, 0);
    check("over_score_l", score_l, 9);
    frames(3);
    check("over_hold", game_over, 1);
    pulse_start();
    check("restart_reset", ball_reset, 1);
    check("restart_score_l", score_l, 0);
    check("restart_score_r", score_r, 0);
    check("restart_vdir", vdir, 1);
    check("restart_over", game_over, 0);
    @(negedge clk);
    pulse_start();
    check("serve_start_ign", ball_reset, 0);
    frames(SERVE_N);
    check("restart_play", ball_en, 1);

    // asynchronous reset mid-play with a latched miss
    frame(MISSL, NONE, NONE);
    frames(POINT_N + SERVE_N);
    frame(BOT, PADR, NONE);
    check("pre_rst_vdir", vdir, 0);
    check("pre_rst_score_r", score_r, 1);
    ev = MISSL;
    @(negedge clk);
    ev = NONE;
    #3 rst_n = 1'b0;
    #1;
    check("async_vdir", vdir, 1);
    check("async_hdir", hdir, 1);
    check("async_en", ball_en, 0);
    check("async_score_r", score_r, 0);
    @(negedge clk);
    rst_n = 1'b1;
    frame(NONE, NONE, NONE);
    check("post_rst_idle", ball_en, 0);
    pulse_start();
    frames(SERVE_N);
    frame(NONE, NONE, NONE);
    check("post_rst_score_r", score_r, 0);
    check("post_rst_en", ball_en, 1);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
